// File: rtl/rib_arb_pkg.sv
// -----------------------------------------------------------------------------
// rib_arb_pkg
// Shared constants for the RIB bus arbiter: bus widths, FSM state encoding,
// master index assignment and a one-hot to index helper.
// -----------------------------------------------------------------------------
package rib_arb_pkg;

  // Existing core bus widths
  localparam int MEM_ADDR_BUS = 32;
  localparam int MEM_BUS      = 32;

  localparam int NUM_MASTERS  = 3;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Master indices: bit position in request/grant/ack vectors
  localparam logic [1:0] M_EX   = 2'd0;
  localparam logic [1:0] M_PC   = 2'd1;
  localparam logic [1:0] M_JTAG = 2'd2;

  // Convert a one-hot master grant to its index; an invalid pattern maps to M_EX
  // and is only ever seen when no grant is valid.
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
    logic [1:0] idx;
    case (oh)
      3'b001:  idx = M_EX;
      3'b010:  idx = M_PC;
      3'b100:  idx = M_JTAG;
      default: idx = M_EX;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rib_arb_prio.sv
// -----------------------------------------------------------------------------
// rib_arb_prio
// Combinational fixed-priority grant encoder for the three RIB masters.
// Priority: JTAG (m2) > EX (m0) > PC fetch (m1).
// Ports:
//   req_i   [2:0] request vector, bit index = master index
//   gnt_o   [2:0] one-hot grant
//   valid_o       at least one request present
// -----------------------------------------------------------------------------
module rib_arb_prio
  import rib_arb_pkg::*;
(
  input  logic [2:0] req_i,
  output logic [2:0] gnt_o,
  output logic       valid_o
);

  // Fixed-priority selection: the debug master may always interrupt the core
  // between transactions, data accesses beat instruction fetch.
  always_comb begin
    gnt_o = 3'b000;
    if (req_i[M_JTAG]) begin
      gnt_o[M_JTAG] = 1'b1;
    end else if (req_i[M_EX]) begin
      gnt_o[M_EX] = 1'b1;
    end else if (req_i[M_PC]) begin
      gnt_o[M_PC] = 1'b1;
    end else begin
      gnt_o = 3'b000;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/rib_arb.sv
// -----------------------------------------------------------------------------
// rib_arb
// Registered RIB bus arbiter/interconnect. Serves one transaction at a time
// from three masters (core EX data port, core PC fetch port, JTAG debug),
// decodes the slave from address bits [SEL_MSB:SEL_LSB], waits for the
// selected slave's ack (with timeout) and returns a one-cycle completion.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mN_addr_i/data_i/we_i/req_i   master request side (N = 0 EX, 1 PC, 2 JTAG)
//   mN_data_o, mN_ack_o      master read data (held) and completion pulse
//   s_addr_o/s_data_o/s_we_o shared registered slave address/write data/we
//   s_req_o                  one-hot slave request
//   s_data_i, s_ack_i        slave read data (slave k at [32k+31:32k]) and ack
//   hold_flag_o              pipeline stall to the core
//   err_o                    error completion pulse (decode error or timeout)
// -----------------------------------------------------------------------------
module rib_arb
  import rib_arb_pkg::*;
#(
  parameter int NUM_SLAVES = 6,
  parameter int TIMEOUT    = 16,
  parameter int SEL_MSB    = 31,
  parameter int SEL_LSB    = 28
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic [MEM_ADDR_BUS-1:0]    m0_addr_i,
  input  logic [MEM_BUS-1:0]         m0_data_i,
  input  logic                       m0_we_i,
  input  logic                       m0_req_i,
  output logic [MEM_BUS-1:0]         m0_data_o,
  output logic                       m0_ack_o,

  input  logic [MEM_ADDR_BUS-1:0]    m1_addr_i,
  input  logic [MEM_BUS-1:0]         m1_data_i,
  input  logic                       m1_we_i,
  input  logic                       m1_req_i,
  output logic [MEM_BUS-1:0]         m1_data_o,
  output logic                       m1_ack_o,

  input  logic [MEM_ADDR_BUS-1:0]    m2_addr_i,
  input  logic [MEM_BUS-1:0]         m2_data_i,
  input  logic                       m2_we_i,
  input  logic                       m2_req_i,
  output logic [MEM_BUS-1:0]         m2_data_o,
  output logic                       m2_ack_o,

  output logic [MEM_ADDR_BUS-1:0]    s_addr_o,
  output logic [MEM_BUS-1:0]         s_data_o,
  output logic                       s_we_o,
  output logic [NUM_SLAVES-1:0]      s_req_o,
  input  logic [MEM_BUS*NUM_SLAVES-1:0] s_data_i,
  input  logic [NUM_SLAVES-1:0]      s_ack_i,

  output logic                       hold_flag_o,
  output logic                       err_o
);

  localparam int SEL_W = SEL_MSB - SEL_LSB + 1;
  // BUSY counter only needs to reach TIMEOUT-1
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Registered state
  logic [1:0]              state_q, state_d;
  logic [1:0]              gnt_q,   gnt_d;
  logic [SEL_W-1:0]        sel_q,   sel_d;
  logic [MEM_ADDR_BUS-1:0] addr_q,  addr_d;
  logic [MEM_BUS-1:0]      wdata_q, wdata_d;
  logic                    we_q,    we_d;
  logic [NUM_SLAVES-1:0]   s_req_q, s_req_d;
  logic [CNT_W-1:0]        cnt_q,   cnt_d;
  logic [2:0]              ack_q,   ack_d;
  logic                    err_q,   err_d;
  logic [MEM_BUS-1:0]      rdata_q [NUM_MASTERS];
  logic [MEM_BUS-1:0]      rdata_d [NUM_MASTERS];

  // Master request side gathered into index-addressable form
  logic [MEM_ADDR_BUS-1:0] m_addr_s  [NUM_MASTERS];
  logic [MEM_BUS-1:0]      m_wdata_s [NUM_MASTERS];
  logic [2:0]              m_we_s;
  logic [2:0]              m_req_s;

  // Arbitration and decode results
  logic [2:0]              arb_gnt_s;
  logic                    arb_valid_s;
  logic [1:0]              arb_idx_s;
  logic [SEL_W-1:0]        req_sel_s;
  logic                    req_sel_ok_s;
  logic [NUM_SLAVES-1:0]   req_onehot_s;

  // Response from the currently selected slave
  logic                    sel_ack_s;
  logic [MEM_BUS-1:0]      sel_rdata_s;

  assign m_addr_s[0]  = m0_addr_i;
  assign m_addr_s[1]  = m1_addr_i;
  assign m_addr_s[2]  = m2_addr_i;
  assign m_wdata_s[0] = m0_data_i;
  assign m_wdata_s[1] = m1_data_i;
  assign m_wdata_s[2] = m2_data_i;
  assign m_we_s       = {m2_we_i,  m1_we_i,  m0_we_i};
  assign m_req_s      = {m2_req_i, m1_req_i, m0_req_i};

  rib_arb_prio u_prio (
    .req_i   (m_req_s),
    .gnt_o   (arb_gnt_s),
    .valid_o (arb_valid_s)
  );

  assign arb_idx_s = onehot_to_idx(arb_gnt_s);

  // Slave decode of the winning master's address; out-of-range selects are
  // answered locally with an error instead of touching any slave.
  always_comb begin
    req_sel_s    = m_addr_s[arb_idx_s][SEL_MSB:SEL_LSB];
    req_sel_ok_s = (32'(req_sel_s) < 32'(NUM_SLAVES));
    for (int k = 0; k < NUM_SLAVES; k++) begin
      req_onehot_s[k] = (req_sel_s == SEL_W'(k));
    end
  end

  // AND-OR mux of the selected slave's ack and read data; acks from other
  // slaves are masked out here.
  always_comb begin
    sel_ack_s   = 1'b0;
    sel_rdata_s = 32'd0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      sel_ack_s   = sel_ack_s | ((sel_q == SEL_W'(k)) & s_ack_i[k]);
      sel_rdata_s = sel_rdata_s
                  | ({MEM_BUS{sel_q == SEL_W'(k)}} & s_data_i[MEM_BUS*k +: MEM_BUS]);
    end
  end

  // Transaction FSM: arbitrate in IDLE, wait for ack or timeout in BUSY,
  // pulse completion in RESP.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    s_req_d = s_req_q;
    cnt_d   = cnt_q;
    ack_d   = 3'b000;
    err_d   = 1'b0;
    for (int m = 0; m < NUM_MASTERS; m++) begin
      rdata_d[m] = rdata_q[m];
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (arb_valid_s) begin
          gnt_d   = arb_idx_s;
          addr_d  = m_addr_s[arb_idx_s];
          wdata_d = m_wdata_s[arb_idx_s];
          we_d    = m_we_s[arb_idx_s];
          sel_d   = req_sel_s;
          if (req_sel_ok_s) begin
            state_d = ST_BUSY;
            s_req_d = req_onehot_s;
          end else begin
            // Decode error: complete immediately, read data forced to zero
            state_d            = ST_RESP;
            s_req_d            = '0;
            ack_d[arb_idx_s]   = 1'b1;
            err_d              = 1'b1;
            rdata_d[arb_idx_s] = 32'd0;
          end
        end else begin
          s_req_d = '0;
        end
      end

      ST_BUSY: begin
        if (sel_ack_s) begin
          state_d      = ST_RESP;
          s_req_d      = '0;
          cnt_d        = '0;
          ack_d[gnt_q] = 1'b1;
          if (!we_q) begin
            rdata_d[gnt_q] = sel_rdata_s;
          end else begin
            rdata_d[gnt_q] = rdata_q[gnt_q];
          end
        end else if (cnt_q == CNT_LAST) begin
          // Slave never answered within TIMEOUT cycles
          state_d        = ST_RESP;
          s_req_d        = '0;
          cnt_d          = '0;
          ack_d[gnt_q]   = 1'b1;
          err_d          = 1'b1;
          rdata_d[gnt_q] = 32'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        s_req_d = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = ST_IDLE;
        s_req_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= M_EX;
      sel_q   <= '0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      we_q    <= 1'b0;
      s_req_q <= '0;
      cnt_q   <= '0;
      ack_q   <= 3'b000;
      err_q   <= 1'b0;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        rdata_q[m] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      s_req_q <= s_req_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      for (int m = 0; m < NUM_MASTERS; m++) begin
        rdata_q[m] <= rdata_d[m];
      end
    end
  end

  assign s_addr_o  = addr_q;
  assign s_data_o  = wdata_q;
  assign s_we_o    = we_q;
  assign s_req_o   = s_req_q;
  assign err_o     = err_q;

  assign m0_ack_o  = ack_q[M_EX];
  assign m1_ack_o  = ack_q[M_PC];
  assign m2_ack_o  = ack_q[M_JTAG];
  assign m0_data_o = rdata_q[0];
  assign m1_data_o = rdata_q[1];
  assign m2_data_o = rdata_q[2];

  // Stall the core while any master waits, released in the completion cycle
  assign hold_flag_o = (|m_req_s) & (state_q != ST_RESP);

endmodule

// File: tb/tb_rib_arb.sv
// -----------------------------------------------------------------------------
// tb_rib_arb
// Self-checking bench for rib_arb: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_rib_arb;

  localparam int NS = 6;
  localparam int TO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [31:0]          m_addr  [3];
  logic [31:0]          m_wdata [3];
  logic                 m_we    [3];
  logic                 m_req   [3];
  logic [31:0]          dut_data[3];
  logic                 dut_ack [3];
  logic [31:0]          s_addr_o, s_data_o;
  logic                 s_we_o;
  logic [NS-1:0]        s_req_o;
  logic [32*NS-1:0]     s_data_i;
  logic [NS-1:0]        s_ack_i;
  logic                 hold_flag_o, err_o;

  // Per-master transaction parameters for the slave model
  int                   m_wait [3];
  logic [31:0]          m_rd   [3];
  bit                   m_drop [3];

  // Reference model: last read data seen by each master
  logic [31:0]          exp_data [3];

  int n_checks = 0;
  int n_err    = 0;

  rib_arb #(.NUM_SLAVES(NS), .TIMEOUT(TO), .SEL_MSB(31), .SEL_LSB(28)) dut (
    .clk(clk), .rst(rst),
    .m0_addr_i(m_addr[0]), .m0_data_i(m_wdata[0]), .m0_we_i(m_we[0]), .m0_req_i(m_req[0]),
    .m0_data_o(dut_data[0]), .m0_ack_o(dut_ack[0]),
    .m1_addr_i(m_addr[1]), .m1_data_i(m_wdata[1]), .m1_we_i(m_we[1]), .m1_req_i(m_req[1]),
    .m1_data_o(dut_data[1]), .m1_ack_o(dut_ack[1]),
    .m2_addr_i(m_addr[2]), .m2_data_i(m_wdata[2]), .m2_we_i(m_we[2]), .m2_req_i(m_req[2]),
    .m2_data_o(dut_data[2]), .m2_ack_o(dut_ack[2]),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_req_o(s_req_o),
    .s_data_i(s_data_i), .s_ack_i(s_ack_i),
    .hold_flag_o(hold_flag_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic any_req();
    return m_req[0] | m_req[1] | m_req[2];
  endfunction

  task automatic set_master(input int i, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input int wt,
                            input logic [31:0] rd, input bit drop);
    m_addr[i]  = addr;
    m_we[i]    = we;
    m_wdata[i] = wdata;
    m_wait[i]  = wt;
    m_rd[i]    = rd;
    m_drop[i]  = drop;
    m_req[i]   = 1'b1;
  endtask

  // Everything zero after reset, model data cleared
  task automatic check_reset(input string tag);
    chk({tag, "_sreq"},  32'(s_req_o), 32'd0);
    chk({tag, "_saddr"}, s_addr_o, 32'd0);
    chk({tag, "_sdata"}, s_data_o, 32'd0);
    chk({tag, "_swe"},   32'(s_we_o), 32'd0);
    chk({tag, "_err"},   32'(err_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk({tag, "_ack"},  32'(dut_ack[i]), 32'd0);
      chk({tag, "_data"}, dut_data[i], 32'd0);
    end
  endtask

  // One full transaction, starting at a negedge in an IDLE cycle. The winner
  // is chosen by fixed priority m2 > m0 > m1 from the current requests.
  task automatic do_txn();
    int g, selv, w;
    bit ok, err_exp;
    logic [NS-1:0] oh;
    if (m_req[2]) g = 2;
    else if (m_req[0]) g = 0;
    else g = 1;
    selv = int'(m_addr[g][31:28]);
    ok   = (selv < NS);
    w    = m_wait[g];
    #1;
    chk("idle_hold", 32'(hold_flag_o), 32'(any_req()));
    chk("idle_sreq", 32'(s_req_o), 32'd0);
    chk("idle_err",  32'(err_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (ok) begin
      oh = '0;
      oh[selv] = 1'b1;
      for (int b = 0; b < TO; b++) begin
        chk("busy_sreq",  32'(s_req_o), 32'(oh));
        chk("busy_saddr", s_addr_o, m_addr[g]);
        chk("busy_swe",   32'(s_we_o), 32'(m_we[g]));
        chk("busy_sdata", s_data_o, m_wdata[g]);
        chk("busy_hold",  32'(hold_flag_o), 32'(any_req()));
        chk("busy_ack",   32'({dut_ack[2], dut_ack[1], dut_ack[0]}), 32'd0);
        chk("busy_err",   32'(err_o), 32'd0);
        if (b == 0 && m_drop[g]) m_req[g] = 1'b0;
        for (int k = 0; k < NS; k++) s_data_i[32*k +: 32] = $urandom;
        s_ack_i = '0;
        if (b == w) begin
          s_ack_i[selv] = 1'b1;
          s_data_i[32*selv +: 32] = m_rd[g];
        end else begin
          s_ack_i[(selv + 1) % NS] = 1'b1;  // stray ack from another slave
        end
        @(posedge clk);
        @(negedge clk);
        s_ack_i = '0;
        if (b == w) break;
      end
    end
    // Completion cycle
    err_exp = !ok || (w >= TO);
    if (err_exp) exp_data[g] = 32'd0;
    else if (!m_we[g]) exp_data[g] = m_rd[g];
    for (int i = 0; i < 3; i++) begin
      chk("resp_ack",  32'(dut_ack[i]), 32'(i == g));
      chk("resp_data", dut_data[i], exp_data[i]);
    end
    chk("resp_err",  32'(err_o), 32'(err_exp));
    chk("resp_sreq", 32'(s_req_o), 32'd0);
    chk("resp_hold", 32'(hold_flag_o), 32'd0);
    m_req[g] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst      = 1'b1;
    s_data_i = '0;
    s_ack_i  = '0;
    for (int i = 0; i < 3; i++) begin
      m_addr[i] = 32'd0; m_wdata[i] = 32'd0; m_we[i] = 1'b0; m_req[i] = 1'b0;
      m_wait[i] = 0; m_rd[i] = 32'd0; m_drop[i] = 1'b0; exp_data[i] = 32'd0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset");
    chk("reset_hold", 32'(hold_flag_o), 32'd0);
    rst = 1'b0;

    // Single read, zero wait states
    set_master(0, 32'h1000_0004, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0);
    do_txn();

    // Write with three wait states; write leaves m1_data_o untouched
    set_master(1, 32'h2000_0000, 1'b1, 32'h1234_5678, 3, 32'hAAAA_5555, 1'b0);
    do_txn();

    // All three masters at once: served m2, m0, m1
    set_master(0, 32'h4000_0010, 1'b0, 32'h0, 1, 32'h0000_0A0A, 1'b0);
    set_master(1, 32'h5000_0020, 1'b0, 32'h0, 0, 32'h0000_0B0B, 1'b0);
    set_master(2, 32'h0000_0030, 1'b0, 32'h0, 2, 32'h0000_0C0C, 1'b0);
    for (int t = 0; t < 3; t++) do_txn();

    // Decode error
    set_master(0, 32'hF000_0000, 1'b0, 32'h0, 0, 32'h5A5A_5A5A, 1'b0);
    do_txn();

    // Timeout on slave 3, then an ack on the very last allowed cycle
    set_master(0, 32'h3000_0000, 1'b0, 32'h0, TO, 32'h0, 1'b0);
    do_txn();
    set_master(0, 32'h3000_0010, 1'b0, 32'h0, TO - 1, 32'h7777_1111, 1'b0);
    do_txn();

    // Request withdrawn mid-transaction still completes
    set_master(1, 32'h4000_0000, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 1'b1);
    do_txn();

    // Reset during the fourth BUSY cycle of a wait-state access
    set_master(0, 32'h3000_0040, 1'b0, 32'h0, 10, 32'h1111_2222, 1'b0);
    @(posedge clk);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      chk("abort_sreq", 32'(s_req_o), 32'h0000_0008);
    end
    @(negedge clk);
    rst      = 1'b1;
    m_req[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) exp_data[i] = 32'd0;
    check_reset("abort");
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("abort_noack", 32'({dut_ack[2], dut_ack[1], dut_ack[0]}), 32'd0);
      chk("abort_hold",  32'(hold_flag_o), 32'd0);
    end

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 3; i++) begin
        set_master(i, {4'($urandom_range(0, 7)), 28'($urandom)}, 1'($urandom),
                   $urandom, ($urandom_range(0, 9) == 0) ? TO + 2 : $urandom_range(0, 4),
                   $urandom, 1'b0);
        m_req[i] = 1'($urandom);
      end
      if (!any_req()) m_req[$urandom_range(0, 2)] = 1'b1;
      for (int k = 0; k < 3; k++) begin
        if (any_req()) do_txn();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
